fft_frame_ctrl: RTL and testbench
=================================

Name: fft_frame_ctrl

Overview:
Parametrised streaming frame controller for the transform path. Replaces a fixed 16-point, free-running SIPO/PISO arrangement with valid/ready streaming of N real samples per frame. Launches an external N-point transform core through a start/done handshake and selects forward or inverse mode per frame. Inverse mode applies 1/N scaling and conjugation. Returns results as a valid/ready complex stream with frame markers, a core watchdog and error reporting.

Parameters:
N, 16, points per frame; power of 2, minimum 4
W, 64, sample width in bits; signed two's complement
LOG2N, $clog2(N), derived; used for count widths and inverse scaling
TIMEOUT, 1024, maximum cycles allowed in WAIT before abort; 0 disables the watchdog

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
mode  in  1  0 = forward, 1 = inverse; sampled on the first accepted sample of a frame
in_valid  in  1  input sample valid
in_ready  out  1  controller can accept a sample
in_data  in  W  real input sample
in_last  in  1  marks the last sample of a frame
core_start  out  1  one-cycle launch pulse to the core
core_mode  out  1  latched frame mode
core_in_real  out  N*W  buffered frame; sample k at bits [k*W +: W]
core_in_im  out  N*W  constant zero
core_done  in  1  core result valid (level; sampled in WAIT only)
core_out_real  in  N*W  core result, real parts
core_out_im  in  N*W  core result, imaginary parts
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the output sample
out_real  out  W  output real part
out_im  out  W  output imaginary part
out_last  out  1  high on output index N-1
busy  out  1  high when state != FILL or fill count != 0
frame_err  out  1  one-cycle pulse on a framing error or timeout
frame_cnt  out  16  frames completed (last output accepted); wraps at 65535

Behaviour:
- Reset (rst=0, asynchronous): state=FILL; all counts 0; in_ready=1; core_start=0; out_valid=0; out_last=0; frame_err=0; frame_cnt=0; busy=0; core_mode=0. Buffers are not cleared.
- A reset asserted mid-frame or mid-drain aborts immediately. Partial data is discarded and no core_start is issued.
- FILL:
  - in_ready=1.
  - Each in_valid&&in_ready writes buf[idx(cnt)] and increments cnt. idx(cnt)=cnt.
  - mode is latched into core_mode when cnt==0.
  - in_last at cnt<N-1: frame_err pulse next cycle; cnt returns to 0; frame discarded.
  - Handshake at cnt==N-1: go to LAUNCH. If in_last=0 on that beat, frame_err pulses but the frame is still processed.
- LAUNCH: core_start=1 for exactly one cycle; in_ready=0; next state WAIT.
- WAIT:
  - in_ready=0; a watchdog counter increments every cycle.
  - core_done=1 at an edge: capture all N results into the output buffer, apply scaling, go to DRAIN.
  - Watchdog reaches TIMEOUT with core_done=0: frame_err pulse, return to FILL with cnt=0; nothing is output.
  - core_done that is high outside WAIT is ignored.
- Scaling, applied at capture:
  - Forward mode: out = core value unchanged.
  - Inverse mode: real = core_real >>> LOG2N (arithmetic shift). imag = -(core_im >>> LOG2N), truncated to W bits; the most-negative value wraps.
- DRAIN:
  - out_valid=1 starting the cycle after the capture edge. Latency from core_done sampled to first out_valid is 1 cycle.
  - out_real/out_im show element k, k starting at 0.
  - out_valid&&out_ready increments k.
  - While out_valid&&!out_ready, out_real/out_im/out_last hold stable.
  - Handshake at k==N-1: out_valid drops the next cycle, frame_cnt increments, state returns to FILL.
  - in_ready=0 throughout DRAIN; there is no overlap between filling and draining.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

Optional Feature:
Macro FRAME_BITREV_EN.
- Defined: idx(cnt)=bit-reverse of cnt over LOG2N bits, so core_in_real holds the frame in bit-reversed order for an in-place decimation-in-time core. Output order is unchanged (natural).
- Undefined: idx(cnt)=cnt (natural order). The logic is removed entirely.

Test Plan:
- Forward impulse, N=16: inputs 1,0,...,0 with in_last on the 16th sample. Expect one core_start pulse and core_mode=0. Bench core echoes all-ones real after 5 cycles. Expect 16 outputs of real=1, im=0; out_last only on the 16th; frame_cnt=1.
- Inverse scaling, mode=1: bench core returns real=160 and im=32 on every point. Expect every output real=10, im=-2. Also real=-17 gives -2 (arithmetic shift).
- Early in_last asserted on sample 5: expect a frame_err pulse, no core_start, busy=0 afterwards. A following full frame then processes normally.
- Backpressure: out_ready toggled 1,0,0,1 repeatedly. Every sample is delivered exactly once, in order, and held stable while stalled. A reset mid-drain sets out_valid=0 immediately.
- Timeout, TIMEOUT=8 with core_done never asserted: frame_err pulses 8 cycles after entering WAIT. State returns to FILL, in_ready=1, no outputs.
- With FRAME_BITREV_EN: inputs 0..15 give core_in_real slot 1 = 8 and slot 3 = 12.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// fft_frame_ctrl: streaming frame controller for an external N-point transform core.
//
// Collects N real samples over a valid/ready input stream, launches the core with a
// one-cycle core_start, waits for core_done (with a watchdog), captures and scales the
// complex result, then drains it over a valid/ready output stream with out_last on N-1.
// Inverse frames are scaled by 1/N (arithmetic shift) and conjugated at capture.
//
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   mode                 0 forward / 1 inverse, latched on the first sample of a frame
//   in_valid/ready/data/last   input sample stream
//   core_start/mode/in_real/in_im   core launch interface
//   core_done/out_real/out_im       core result interface
//   out_valid/ready/real/im/last    output complex stream
//   busy, frame_err, frame_cnt      status
//
// Optional build macro FRAME_BITREV_EN: frame is written into core_in_real in
// bit-reversed slot order; output order stays natural.
module fft_frame_ctrl #(
  parameter int N       = 16,
  parameter int W       = 64,
  parameter int LOG2N   = $clog2(N),
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           mode,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   in_data,
  input  logic           in_last,
  output logic           core_start,
  output logic           core_mode,
  output logic [N*W-1:0] core_in_real,
  output logic [N*W-1:0] core_in_im,
  input  logic           core_done,
  input  logic [N*W-1:0] core_out_real,
  input  logic [N*W-1:0] core_out_im,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_real,
  output logic [W-1:0]   out_im,
  output logic           out_last,
  output logic           busy,
  output logic           frame_err,
  output logic [15:0]    frame_cnt
);

  localparam int WDW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WDW-1:0]   WD_MAX = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
  localparam logic [LOG2N-1:0] LAST   = LOG2N'(N - 1);

  typedef enum logic [1:0] {FILL, LAUNCH, WAIT, DRAIN} state_t;

  state_t               state_q, state_d;
  logic [LOG2N-1:0]     cnt_q, cnt_d, k_q, k_d, widx;
  logic [WDW-1:0]       wd_q, wd_d;
  logic                 mode_q, mode_d, err_q, err_d;
  logic [15:0]          fcnt_q, fcnt_d;
  logic                 wr_en, cap_en;
  logic [N-1:0][W-1:0]  sbuf_q, ore_q, oim_q, cap_re, cap_im;

`ifdef FRAME_BITREV_EN
  always_comb begin
    widx = '0;
    for (int b = 0; b < LOG2N; b++) widx[b] = cnt_q[LOG2N-1-b];
  end
`else
  assign widx = cnt_q;
`endif

  // Inverse scaling: shift by log2(N); imaginary part also negated (conjugate),
  // wrapping at the most-negative value.
  for (genvar k = 0; k < N; k++) begin : g_cap
    logic signed [W-1:0] cr, ci, sr, si;
    assign cr = core_out_real[k*W +: W];
    assign ci = core_out_im[k*W +: W];
    assign sr = cr >>> LOG2N;
    assign si = -(ci >>> LOG2N);
    assign cap_re[k] = mode_q ? sr : cr;
    assign cap_im[k] = mode_q ? si : ci;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    wd_d    = wd_q;
    mode_d  = mode_q;
    err_d   = 1'b0;
    fcnt_d  = fcnt_q;
    wr_en   = 1'b0;
    cap_en  = 1'b0;
    case (state_q)
      FILL: if (in_valid) begin
        wr_en = 1'b1;
        if (cnt_q == '0) mode_d = mode;
        if (cnt_q == LAST) begin
          state_d = LAUNCH;
          cnt_d   = '0;
          err_d   = !in_last;   // missing marker is reported, frame still runs
        end else if (in_last) begin
          cnt_d = '0;
          err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LAUNCH: begin
        state_d = WAIT;
        wd_d    = '0;
      end
      WAIT: begin
        if (core_done) begin
          cap_en  = 1'b1;
          state_d = DRAIN;
          k_d     = '0;
        end else if (TIMEOUT != 0 && wd_q == WD_MAX) begin
          err_d   = 1'b1;
          state_d = FILL;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      DRAIN: if (out_ready) begin
        if (k_q == LAST) begin
          state_d = FILL;
          k_d     = '0;
          fcnt_d  = fcnt_q + 1'b1;
        end else begin
          k_d = k_q + 1'b1;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FILL;
      cnt_q   <= '0;
      k_q     <= '0;
      wd_q    <= '0;
      mode_q  <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      wd_q    <= wd_d;
      mode_q  <= mode_d;
      err_q   <= err_d;
      fcnt_q  <= fcnt_d;
    end
  end

  // Data buffers are not reset.
  always_ff @(posedge clk) begin
    if (wr_en) sbuf_q[widx] <= in_data;
    if (cap_en) begin
      ore_q <= cap_re;
      oim_q <= cap_im;
    end
  end

  assign in_ready     = (state_q == FILL);
  assign core_start   = (state_q == LAUNCH);
  assign core_mode    = mode_q;
  assign core_in_real = sbuf_q;
  assign core_in_im   = '0;
  assign out_valid    = (state_q == DRAIN);
  assign out_real     = ore_q[k_q];
  assign out_im       = oim_q[k_q];
  assign out_last     = (state_q == DRAIN) && (k_q == LAST);
  assign busy         = (state_q != FILL) || (cnt_q != '0);
  assign frame_err    = err_q;
  assign frame_cnt    = fcnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
module tb_fft_frame_ctrl;
  localparam int N = 16;
  localparam int W = 64;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           mode = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [W-1:0]   in_data = '0;
  logic           in_ready, core_start, core_mode;
  logic [N*W-1:0] core_in_real, core_in_im;
  logic           core_done = 1'b0;
  logic [N*W-1:0] core_out_real = '0, core_out_im = '0;
  logic           out_valid, out_last, busy, frame_err;
  logic           out_ready = 1'b0;
  logic [W-1:0]   out_real, out_im;
  logic [15:0]    frame_cnt;

  fft_frame_ctrl #(.N(N), .W(W), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .core_start(core_start), .core_mode(core_mode),
    .core_in_real(core_in_real), .core_in_im(core_in_im), .core_done(core_done),
    .core_out_real(core_out_real), .core_out_im(core_out_im), .out_valid(out_valid),
    .out_ready(out_ready), .out_real(out_real), .out_im(out_im), .out_last(out_last),
    .busy(busy), .frame_err(frame_err), .frame_cnt(frame_cnt));

  always #5 clk = ~clk;

  typedef struct {
    bit                  md;
    bit                  impulse;
    bit                  drop_last;
    logic signed [W-1:0] cre, cstep, cim;   // core returns re=cre+k*cstep, im=cim
    logic signed [W-1:0] ere, estep, eim;   // expected out re=ere+k*estep, im=eim
  } vec_t;

  vec_t vecs[6];
  int   n_chk = 0, n_fail = 0;
  int   exp_frames = 0;
  bit   pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic send(input int n, input bit with_last, input bit md, input bit imp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy while filling", W'(busy), 1);
      in_valid = 1'b1;
      in_data  = imp ? W'(i == 0) : W'(i);
      in_last  = with_last && (i == n - 1);
      mode     = md;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic launch_and_done(input vec_t v);
    chk("core_start pulse", W'(core_start), 1);
    chk("core_mode", W'(core_mode), W'(v.md));
    chk("frame_err on launch", W'(frame_err), W'(v.drop_last));
    chk("in_ready in launch", W'(in_ready), 0);
    if (v.impulse) begin
      chk("slot0 impulse", core_in_real[0 +: W], 1);
      chk("slot1 impulse", core_in_real[W +: W], 0);
    end else begin
`ifdef FRAME_BITREV_EN
      chk("slot1 bitrev", core_in_real[1*W +: W], 8);
      chk("slot3 bitrev", core_in_real[3*W +: W], 12);
`else
      chk("slot1 natural", core_in_real[1*W +: W], 1);
      chk("slot3 natural", core_in_real[3*W +: W], 3);
`endif
    end
    for (int k = 0; k < N; k++) begin
      core_out_real[k*W +: W] = v.cre + W'(k) * v.cstep;
      core_out_im[k*W +: W]   = v.cim;
    end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 0) chk("single core_start", W'(core_start), 0);
    end
    core_done = 1'b1;
    @(negedge clk);
    core_done = 1'b0;
  endtask

  task automatic drain(input vec_t v);
    int k = 0, cyc = 0;
    logic [W-1:0] e;
    while (k < N && cyc < 200) begin
      if (cyc > 0) @(negedge clk);
      chk("out_valid", W'(out_valid), 1);
      if (cyc == 0) chk("in_ready in drain", W'(in_ready), 0);
      e = v.ere + W'(k) * v.estep;
      chk($sformatf("out_real[%0d]", k), out_real, e);
      chk($sformatf("out_im[%0d]", k), out_im, v.eim);
      chk($sformatf("out_last[%0d]", k), W'(out_last), W'(k == N - 1));
      out_ready = pat[cyc % 4];
      if (pat[cyc % 4]) k++;
      cyc++;
    end
    chk("drain completed in budget", W'(k), W'(N));
    @(negedge clk);
    out_ready = 1'b0;
    exp_frames++;
    chk("out_valid after last", W'(out_valid), 0);
    chk("frame_cnt", W'(frame_cnt), W'(exp_frames));
    chk("in_ready after drain", W'(in_ready), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    vecs[0] = '{0, 1, 0,   1,  0,  0,   1, 0,  0};
    vecs[1] = '{0, 0, 0,  -5,  3,  7,  -5, 3,  7};
    vecs[2] = '{1, 0, 0, 160,  0, 32,  10, 0, -2};
    vecs[3] = '{1, 0, 0, -17,  0, -17, -2, 0,  2};
    vecs[4] = '{1, 0, 0, 160, 16, 64'sh8000_0000_0000_0000,
                10, 1, 64'sh0800_0000_0000_0000};
    vecs[5] = '{0, 0, 1, 100, -1, -3, 100, -1, -3};

    // reset state
    repeat (2) @(negedge clk);
    chk("rst in_ready", W'(in_ready), 1);
    chk("rst core_start", W'(core_start), 0);
    chk("rst out_valid", W'(out_valid), 0);
    chk("rst out_last", W'(out_last), 0);
    chk("rst frame_err", W'(frame_err), 0);
    chk("rst frame_cnt", W'(frame_cnt), 0);
    chk("rst busy", W'(busy), 0);
    chk("rst core_mode", W'(core_mode), 0);
    rst = 1'b1;

    // main table
    for (int i = 0; i < 6; i++) begin
      send(N, !vecs[i].drop_last, vecs[i].md, vecs[i].impulse);
      launch_and_done(vecs[i]);
      drain(vecs[i]);
    end

    // early in_last on sample 5
    send(5, 1'b1, 1'b0, 1'b0);
    chk("early err pulse", W'(frame_err), 1);
    chk("early no start", W'(core_start), 0);
    chk("early busy", W'(busy), 0);
    chk("early in_ready", W'(in_ready), 1);
    @(negedge clk);
    chk("early err one cycle", W'(frame_err), 0);
    chk("early still no start", W'(core_start), 0);
    send(N, 1'b1, 1'b0, 1'b0);
    launch_and_done(vecs[1]);
    drain(vecs[1]);

    // watchdog timeout: core never answers
    send(N, 1'b1, 1'b1, 1'b0);
    chk("to core_start", W'(core_start), 1);
    begin
      int seen = 0;
      for (int c = 1; c <= 20 && seen == 0; c++) begin
        @(negedge clk);
        if (frame_err) seen = c;
        else if (c < 20) chk("to no output", W'(out_valid), 0);
      end
      chk("timeout latency", W'(seen), 9);
    end
    chk("to in_ready", W'(in_ready), 1);
    chk("to busy", W'(busy), 0);
    chk("to out_valid", W'(out_valid), 0);
    chk("to frame_cnt", W'(frame_cnt), W'(exp_frames));
    @(negedge clk);
    chk("to err one cycle", W'(frame_err), 0);

    // reset mid-drain
    send(N, 1'b1, 1'b0, 1'b0);
    launch_and_done(vecs[1]);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre-reset out_real", out_real, W'(-5 + 3*3));
    #2 rst = 1'b0;
    #1;
    chk("mid-drain rst out_valid", W'(out_valid), 0);
    chk("mid-drain rst in_ready", W'(in_ready), 1);
    chk("mid-drain rst busy", W'(busy), 0);
    chk("mid-drain rst frame_cnt", W'(frame_cnt), 0);
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post-rst out_valid", W'(out_valid), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
